// File: rtl/clk_rst_seq.sv
// ============================================================================
// Module   : clk_rst_seq
// Brief    : Lock-qualified reset sequencer releasing core, output and data
//            domain resets in staggered order once PLL lock is stable.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module clk_rst_seq #(
  parameter int LOCK_STABLE = 16,
  parameter int STAGE_DLY   = 8,
  parameter int CNT_W       = 8
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             pll_lock_i,
  input  logic             soft_rst_i,
  output logic             rst_c_n_o,
  output logic             rst_o_n_o,
  output logic             rst_d_n_o,
  output logic             ready_o,
  output logic [CNT_W-1:0] loss_cnt_o
);

  localparam int c_MAX_LIM = (LOCK_STABLE > STAGE_DLY) ? LOCK_STABLE : STAGE_DLY;
  localparam int c_CW      = $clog2(c_MAX_LIM) + 1;

  localparam logic [c_CW-1:0] c_LS_LAST = c_CW'(LOCK_STABLE - 1);
  localparam logic [c_CW-1:0] c_SD_LAST = c_CW'(STAGE_DLY - 1);

  localparam logic [2:0] c_S_RESET  = 3'd0;
  localparam logic [2:0] c_S_WAIT   = 3'd1;
  localparam logic [2:0] c_S_STABLE = 3'd2;
  localparam logic [2:0] c_S_REL_C  = 3'd3;
  localparam logic [2:0] c_S_REL_O  = 3'd4;
  localparam logic [2:0] c_S_REL_D  = 3'd5;
  localparam logic [2:0] c_S_RUN    = 3'd6;
  localparam logic [2:0] c_S_HOLD   = 3'd7;

  logic             sync1_q, sync2_q;
  logic             lock_s;
  logic [2:0]       state_q, state_d;
  logic [c_CW-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0] loss_q, loss_d;
  logic             rst_c_q, rst_c_d;
  logic             rst_o_q, rst_o_d;
  logic             rst_d_q, rst_d_d;
  logic             ready_q, ready_d;

  assign lock_s = sync2_q;

  // The synchroniser stays clear while in RESET so the first sample is
  // taken only after the reset release has been absorbed.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      state_q <= c_S_RESET;
      cnt_q   <= '0;
      loss_q  <= '0;
      rst_c_q <= 1'b0;
      rst_o_q <= 1'b0;
      rst_d_q <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      if (state_q != c_S_RESET) begin
        sync1_q <= pll_lock_i;
        sync2_q <= sync1_q;
      end
      state_q <= state_d;
      cnt_q   <= cnt_d;
      loss_q  <= loss_d;
      rst_c_q <= rst_c_d;
      rst_o_q <= rst_o_d;
      rst_d_q <= rst_d_d;
      ready_q <= ready_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    loss_d  = loss_q;
    case (state_q)
      c_S_RESET: state_d = c_S_WAIT;
      c_S_WAIT: begin
        if (lock_s) begin
          state_d = c_S_STABLE;
          cnt_d   = '0;
        end
      end
      default: begin
        if (!lock_s) begin
          state_d = c_S_WAIT;
          cnt_d   = '0;
          if (loss_q != {CNT_W{1'b1}}) loss_d = loss_q + 1'b1;
        end else if (soft_rst_i) begin
          state_d = c_S_HOLD;
          cnt_d   = '0;
        end else begin
          case (state_q)
            c_S_HOLD: begin
              state_d = c_S_STABLE;
              cnt_d   = '0;
            end
            c_S_STABLE: begin
              if (cnt_q == c_LS_LAST) begin
                state_d = c_S_REL_C;
                cnt_d   = '0;
              end else begin
                cnt_d = cnt_q + 1'b1;
              end
            end
            c_S_REL_C, c_S_REL_O, c_S_REL_D: begin
              if (cnt_q == c_SD_LAST) begin
                state_d = state_q + 3'd1;
                cnt_d   = '0;
              end else begin
                cnt_d = cnt_q + 1'b1;
              end
            end
            default: ;
          endcase
        end
      end
    endcase
  end

  always_comb begin
    rst_c_d = state_d inside {c_S_REL_C, c_S_REL_O, c_S_REL_D, c_S_RUN};
    rst_o_d = state_d inside {c_S_REL_O, c_S_REL_D, c_S_RUN};
    rst_d_d = state_d inside {c_S_REL_D, c_S_RUN};
    ready_d = (state_d == c_S_RUN);
  end

  assign rst_c_n_o  = rst_c_q;
  assign rst_o_n_o  = rst_o_q;
  assign rst_d_n_o  = rst_d_q;
  assign ready_o    = ready_q;
  assign loss_cnt_o = loss_q;

endmodule

`default_nettype wire

// File: tb/tb_clk_rst_seq.sv
// ============================================================================
// Module   : tb_clk_rst_seq
// Brief    : Self-checking bench for clk_rst_seq against an elapsed-time model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_clk_rst_seq;

  localparam int LS   = 16;
  localparam int SD   = 8;
  localparam int CW   = 2;
  localparam int LMAX = (1 << CW) - 1;

  logic          clk      = 1'b0;
  logic          rst_n    = 1'b1;
  logic          pll_lock = 1'b0;
  logic          soft_rst = 1'b0;
  logic          rst_c_n, rst_o_n, rst_d_n, ready;
  logic [CW-1:0] loss_cnt;

  int checks   = 0;
  int failures = 0;
  int e_cur    = 0;
  bit chk_en   = 1'b0;

  always #5 clk = ~clk;

  clk_rst_seq #(.LOCK_STABLE(LS), .STAGE_DLY(SD), .CNT_W(CW)) dut (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
    .pll_lock_i (pll_lock),
    .soft_rst_i (soft_rst),
    .rst_c_n_o  (rst_c_n),
    .rst_o_n_o  (rst_o_n),
    .rst_d_n_o  (rst_d_n),
    .ready_o    (ready),
    .loss_cnt_o (loss_cnt)
  );

  // Model: mode 0 = waiting for lock, 1 = qualifying/releasing since m_start,
  // 2 = held by soft reset. Outputs follow from elapsed edges since m_start.
  int m_mode  = 0;
  int m_armed = 0;
  int m_start = 0;
  int m_edge  = 0;
  int m_loss  = 0;
  bit m_s1 = 1'b0, m_s2 = 1'b0, m_ls = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode = 0; m_armed = 0; m_loss = 0; m_s1 = 1'b0; m_s2 = 1'b0;
    end else begin
      m_edge = m_edge + 1;
      m_ls   = m_s2;
      if (m_armed == 0) begin
        m_armed = 1;
      end else begin
        if (m_mode == 0) begin
          if (m_ls) begin m_mode = 1; m_start = m_edge; end
        end else if (!m_ls) begin
          m_mode = 0;
          if (m_loss < LMAX) m_loss = m_loss + 1;
        end else if (soft_rst) begin
          m_mode = 2;
        end else if (m_mode == 2) begin
          m_mode = 1; m_start = m_edge;
        end
        m_s2 = m_s1;
        m_s1 = pll_lock;
      end
    end
  end

  function automatic int exp_rel(int thr);
    return (m_mode == 1 && (m_edge - m_start) >= thr) ? 1 : 0;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks = checks + 1;
    if (act != exp) begin
      failures = failures + 1;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_rst_c_n", int'(rst_c_n),  exp_rel(LS));
      check("model_rst_o_n", int'(rst_o_n),  exp_rel(LS + SD));
      check("model_rst_d_n", int'(rst_d_n),  exp_rel(LS + 2*SD));
      check("model_ready",   int'(ready),    exp_rel(LS + 3*SD));
      check("model_loss",    int'(loss_cnt), m_loss);
    end
  end

  task automatic goto(input int tgt);
    repeat (tgt - e_cur) @(posedge clk);
    e_cur = tgt;
    #1;
  endtask

  task automatic release_rst();
    rst_n = 1'b1;
    e_cur = -1;
    goto(0);
  endtask

  int lock_left = 0;
  int sr_left   = 0;

  initial begin
    pll_lock = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_rst_c_n", int'(rst_c_n), 0);
    check("reset_rst_d_n", int'(rst_d_n), 0);
    check("reset_ready",   int'(ready),   0);
    check("reset_loss",    int'(loss_cnt), 0);
    chk_en = 1'b1;

    // Power-up release with lock already present
    release_rst();
    goto(18); check("pu_c_e18", int'(rst_c_n), 0);
    goto(19); check("pu_c_e19", int'(rst_c_n), 1); check("pu_o_e19", int'(rst_o_n), 0);
    goto(26); check("pu_o_e26", int'(rst_o_n), 0);
    goto(27); check("pu_o_e27", int'(rst_o_n), 1);
    goto(34); check("pu_d_e34", int'(rst_d_n), 0);
    goto(35); check("pu_d_e35", int'(rst_d_n), 1);
    goto(42); check("pu_rdy_e42", int'(ready), 0);
    goto(43); check("pu_rdy_e43", int'(ready), 1); check("pu_loss", int'(loss_cnt), 0);

    // Restart, then a single-cycle lock glitch mid-qualification
    #2 rst_n = 1'b0;
    #1 check("rst_async_c", int'(rst_c_n), 0);
    @(posedge clk); #1;
    release_rst();
    goto(11); pll_lock = 1'b0;
    goto(12); pll_lock = 1'b1;
    goto(13); check("gl_loss_e13", int'(loss_cnt), 0);
    goto(14); check("gl_loss_e14", int'(loss_cnt), 1);
    goto(19); check("gl_c_e19", int'(rst_c_n), 0);
    goto(30); check("gl_c_e30", int'(rst_c_n), 0);
    goto(31); check("gl_c_e31", int'(rst_c_n), 1);
    goto(54); check("gl_rdy_e54", int'(ready), 0);
    goto(55); check("gl_rdy_e55", int'(ready), 1);

    // Lock drop of 5 cycles while running
    goto(60); pll_lock = 1'b0;
    goto(62); check("drop_rdy_a1", int'(ready), 1);
    goto(63); check("drop_rdy_a2", int'(ready), 0);
    check("drop_c_a2", int'(rst_c_n), 0); check("drop_loss", int'(loss_cnt), 2);
    goto(65); pll_lock = 1'b1;
    goto(83); check("drop_c_e83", int'(rst_c_n), 0);
    goto(84); check("drop_c_e84", int'(rst_c_n), 1);
    goto(107); check("drop_rdy_e107", int'(ready), 0);
    goto(108); check("drop_rdy_e108", int'(ready), 1);

    // Soft reset pulse of 3 cycles while running
    goto(110); soft_rst = 1'b1;
    goto(111); check("sr_c_e111", int'(rst_c_n), 0); check("sr_rdy_e111", int'(ready), 0);
    goto(113); soft_rst = 1'b0;
    goto(129); check("sr_c_e129", int'(rst_c_n), 0);
    goto(130); check("sr_c_e130", int'(rst_c_n), 1); check("sr_loss", int'(loss_cnt), 2);

    // Soft reset on the same edge as a lock loss
    goto(132); pll_lock = 1'b0;
    goto(134); soft_rst = 1'b1;
    goto(135); soft_rst = 1'b0; check("srl_loss", int'(loss_cnt), 3);
    goto(136); pll_lock = 1'b1;

    // Two further losses must saturate the counter
    goto(142); pll_lock = 1'b0;
    goto(146); pll_lock = 1'b1;
    goto(152); pll_lock = 1'b0;
    goto(156); pll_lock = 1'b1; check("sat_loss", int'(loss_cnt), 3);

    // Asynchronous reset in the middle of the output-domain stage
    goto(185); check("ro_o", int'(rst_o_n), 1); check("ro_d", int'(rst_d_n), 0);
    #2 rst_n = 1'b0;
    #1;
    check("ar_c", int'(rst_c_n), 0); check("ar_o", int'(rst_o_n), 0);
    check("ar_loss", int'(loss_cnt), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Randomised lock bursts, soft resets and rare reset pulses
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      if (lock_left > 0) begin
        lock_left = lock_left - 1;
      end else begin
        pll_lock  = ~pll_lock;
        lock_left = pll_lock ? int'($urandom_range(5, 90)) : int'($urandom_range(1, 6));
      end
      if (sr_left > 0) sr_left = sr_left - 1;
      else if ($urandom_range(0, 99) < 2) sr_left = int'($urandom_range(1, 4));
      soft_rst = (sr_left > 0);
      if ($urandom_range(0, 999) == 0) begin
        #2 rst_n = 1'b0;
        #4 rst_n = 1'b1;
      end
    end
    @(posedge clk); #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
